// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

    localparam int unsigned ODSEL_W      = 6;
    localparam int unsigned RELOCK_CNT_W = 8;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } pll_seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer with serialized ODSEL reconfiguration.
// Optional feature macro: PLL_SEQ_RELOCK_CNT_EN (enables relock_count).
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned        RESET_CYCLES        = 270,
    parameter int unsigned        LOCK_TIMEOUT_CYCLES = 27000,
    parameter int unsigned        STABLE_CYCLES       = 2700,
    parameter int unsigned        MAX_RETRIES         = 7,
    parameter logic [ODSEL_W-1:0] ODSEL_DEFAULT       = 6'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_lock,
    output logic                    pll_reset,
    output logic [ODSEL_W-1:0]      pll_odsel,
    output logic                    sys_rst,
    output logic                    ready,
    output logic                    fault,
    input  logic                    cfg_req,
    input  logic [ODSEL_W-1:0]      cfg_odsel,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic [RELOCK_CNT_W-1:0] relock_count
);

    localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    pll_seq_state_t     state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [ODSEL_W-1:0] odsel_d;
    logic               busy_d, done_d;
    logic               pll_reset_d, sys_rst_d, ready_d, fault_d;
    logic               lock_s;
    logic               lock_loss;
    logic               cfg_accept;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign lock_loss  = (state_q == S_RUN) && !lock_s;
    assign cfg_accept = (state_q == S_RUN) && cfg_req && !cfg_busy;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            retry_q   <= '0;
            pll_odsel <= ODSEL_DEFAULT;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            retry_q   <= retry_d;
            pll_odsel <= odsel_d;
            cfg_busy  <= busy_d;
            cfg_done  <= done_d;
            pll_reset <= pll_reset_d;
            sys_rst   <= sys_rst_d;
            ready     <= ready_d;
            fault     <= fault_d;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state
    // so they are valid in the first cycle of every state.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        retry_d   = retry_q;
        odsel_d   = pll_odsel;
        busy_d    = cfg_busy;
        done_d    = 1'b0;

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q >= RST_W'(RESET_CYCLES)) begin
                    state_d   = S_WAIT_LOCK;
                    rst_cnt_d = '0;
                    to_cnt_d  = TO_W'(1);
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    // The lock_s cycle seen here is the first stable cycle.
                    state_d   = S_STABLE;
                    stb_cnt_d = STB_W'(1);
                    to_cnt_d  = '0;
                end else if (to_cnt_q >= TO_W'(LOCK_TIMEOUT_CYCLES)) begin
                    to_cnt_d = '0;
                    if (retry_q < RTY_W'(MAX_RETRIES)) begin
                        retry_d   = retry_q + RTY_W'(1);
                        state_d   = S_RESET;
                        rst_cnt_d = RST_W'(1);
                    end else begin
                        state_d = S_FAULT;
                        busy_d  = 1'b0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d   = S_WAIT_LOCK;
                    stb_cnt_d = '0;
                    to_cnt_d  = TO_W'(1);
                end else if (stb_cnt_q >= STB_W'(STABLE_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    stb_cnt_d = '0;
                    if (cfg_busy) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            S_RUN: begin
                retry_d = '0;
                if (lock_loss || cfg_accept) begin
                    state_d   = S_RESET;
                    rst_cnt_d = RST_W'(1);
                end
                if (cfg_accept) begin
                    odsel_d = cfg_odsel;
                    busy_d  = 1'b1;
                end
            end
            S_FAULT: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        pll_reset_d = (state_d == S_RESET) || (state_d == S_FAULT);
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic [RELOCK_CNT_W-1:0] relock_q;

    // Saturating count of lock losses observed while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            relock_q <= '0;
        end else if (lock_loss && (relock_q != {RELOCK_CNT_W{1'b1}})) begin
            relock_q <= relock_q + RELOCK_CNT_W'(1);
        end
    end

    assign relock_count = relock_q;
`else
    assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer (small timing parameters).
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

`ifdef PLL_SEQ_RELOCK_CNT_EN
    localparam bit RELOCK_EN = 1'b1;
`else
    localparam bit RELOCK_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pll_lock;
    logic                    pll_reset;
    logic [ODSEL_W-1:0]      pll_odsel;
    logic                    sys_rst;
    logic                    ready;
    logic                    fault;
    logic                    cfg_req;
    logic [ODSEL_W-1:0]      cfg_odsel;
    logic                    cfg_busy;
    logic                    cfg_done;
    logic [RELOCK_CNT_W-1:0] relock_count;

    int checks = 0;
    int errors = 0;
    int n;
    bit saw_done;

    pll_lock_sequencer #(
        .RESET_CYCLES        (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .STABLE_CYCLES       (8),
        .MAX_RETRIES         (2),
        .ODSEL_DEFAULT       (6'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .pll_odsel    (pll_odsel),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .cfg_req      (cfg_req),
        .cfg_odsel    (cfg_odsel),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rc_exp(input int cnt);
        return RELOCK_EN ? 32'(cnt) : 32'd0;
    endfunction

    // Lock loss in RUN followed by a full re-sequence back to RUN.
    task automatic lose_lock();
        int k;
        step();
        pll_lock = 1'b0;
        step();
        chk("loss_ready_hold1", 32'(ready), 32'd1);
        step();
        chk("loss_ready_hold2", 32'(ready), 32'd1);
        step();
        chk("loss_ready_fall", 32'(ready), 32'd0);
        chk("loss_sys_rst", 32'(sys_rst), 32'd1);
        pll_lock = 1'b1;
        k = 0;
        while (ready !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("relock_latency", 32'(k), 32'd12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        pll_lock  = 1'b0;
        cfg_req   = 1'b0;
        cfg_odsel = '0;
        step();
        step();

        // Reset values.
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_sys_rst", 32'(sys_rst), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_relock", 32'(relock_count), 32'd0);
        chk("rst_odsel", 32'(pll_odsel), 32'd0);
        rst = 1'b0;

        // Clean start: lock raised in cycle 6, RUN in cycle 16.
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 6) pll_lock = 1'b1;
            chk("start_pll_reset", 32'(pll_reset), 32'(c <= 4));
            chk("start_ready", 32'(ready), 32'(c >= 16));
            chk("start_sys_rst", 32'(sys_rst), 32'(c < 16));
        end
        chk("start_cfg_busy", 32'(cfg_busy), 32'd0);

        // Reconfiguration to ODSEL 5.
        step();
        cfg_req   = 1'b1;
        cfg_odsel = 6'd5;
        chk("cfg_odsel_before", 32'(pll_odsel), 32'd0);
        step();
        chk("cfg_busy_set", 32'(cfg_busy), 32'd1);
        chk("cfg_odsel_latched", 32'(pll_odsel), 32'd5);
        chk("cfg_pll_reset", 32'(pll_reset), 32'd1);
        chk("cfg_ready_low", 32'(ready), 32'd0);
        n = 0;
        while (cfg_done !== 1'b1 && n < 40) begin
            step();
            n++;
            if (pll_reset === 1'b0) chk("cfg_odsel_hold", 32'(pll_odsel), 32'd5);
        end
        chk("cfg_done_latency", 32'(n), 32'd12);
        chk("cfg_busy_clear", 32'(cfg_busy), 32'd0);
        chk("cfg_ready", 32'(ready), 32'd1);
        cfg_req = 1'b0;
        step();
        chk("cfg_done_pulse", 32'(cfg_done), 32'd0);
        chk("cfg_busy_idle", 32'(cfg_busy), 32'd0);

        // Lock loss in RUN.
        lose_lock();
        chk("relock_count_1", 32'(relock_count), rc_exp(1));

        // Simultaneous lock loss and cfg request.
        step();
        pll_lock = 1'b0;
        step();
        step();
        cfg_req   = 1'b1;
        cfg_odsel = 6'd9;
        step();
        chk("sim_odsel", 32'(pll_odsel), 32'd9);
        chk("sim_busy", 32'(cfg_busy), 32'd1);
        chk("sim_relock", 32'(relock_count), rc_exp(2));
        chk("sim_ready", 32'(ready), 32'd0);
        pll_lock = 1'b1;
        n = 0;
        while (cfg_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("sim_done_latency", 32'(n), 32'd12);
        chk("sim_busy_clear", 32'(cfg_busy), 32'd0);
        cfg_req = 1'b0;
        step();
        chk("sim_done_pulse", 32'(cfg_done), 32'd0);

        // Saturation: 300 lock losses in total.
        for (int i = 0; i < 298; i++) lose_lock();
        chk("relock_saturate", 32'(relock_count), rc_exp(255));

        // Fault during reconfiguration.
        step();
        cfg_req   = 1'b1;
        cfg_odsel = 6'd3;
        pll_lock  = 1'b0;
        step();
        chk("rf_busy", 32'(cfg_busy), 32'd1);
        chk("rf_odsel", 32'(pll_odsel), 32'd3);
        n = 0;
        saw_done = 1'b0;
        while (fault !== 1'b1 && n < 200) begin
            step();
            n++;
            if (cfg_done === 1'b1) saw_done = 1'b1;
        end
        chk("rf_fault_latency", 32'(n), 32'd72);
        chk("rf_busy_clear", 32'(cfg_busy), 32'd0);
        chk("rf_no_done", 32'(saw_done), 32'd0);
        chk("rf_pll_reset", 32'(pll_reset), 32'd1);

        // rst aborts and discards latched ODSEL.
        rst     = 1'b1;
        cfg_req = 1'b0;
        step();
        chk("abort_odsel", 32'(pll_odsel), 32'd0);
        chk("abort_fault", 32'(fault), 32'd0);
        chk("abort_relock", 32'(relock_count), 32'd0);
        chk("abort_pll_reset", 32'(pll_reset), 32'd1);

        // Lock glitch in S_STABLE after 5 stable cycles.
        step();
        rst = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 6)  pll_lock = 1'b1;
            if (c == 11) pll_lock = 1'b0;
            if (c == 12) pll_lock = 1'b1;
            if (c == 13) chk("glitch_state13", 32'(dut.state_q), 32'(S_STABLE));
            if (c == 14) chk("glitch_state14", 32'(dut.state_q), 32'(S_WAIT_LOCK));
            if (c == 14) chk("glitch_pll_reset", 32'(pll_reset), 32'd0);
            if (c == 16) chk("glitch_ready16", 32'(ready), 32'd0);
            if (c == 21) chk("glitch_ready21", 32'(ready), 32'd0);
            if (c == 22) chk("glitch_ready22", 32'(ready), 32'd1);
        end

        // Timeout rounds then fault, held until rst.
        rst      = 1'b1;
        pll_lock = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (c == 24) chk("to_wait24", 32'(pll_reset), 32'd0);
            if (c == 25) chk("to_retry25", 32'(pll_reset), 32'd1);
            if (c == 28) chk("to_retry28", 32'(pll_reset), 32'd1);
            if (c == 29) chk("to_wait29", 32'(pll_reset), 32'd0);
            if (c == 72) chk("to_fault72", 32'(fault), 32'd0);
            if (c == 73) chk("to_fault73", 32'(fault), 32'd1);
        end
        chk("fault_hold", 32'(fault), 32'd1);
        chk("fault_pll_reset", 32'(pll_reset), 32'd1);
        chk("fault_sys_rst", 32'(sys_rst), 32'd1);
        chk("fault_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        step();
        chk("fault_cleared", 32'(fault), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
